fft_seq_ctrl: RTL and testbench
===============================

# fft_seq_ctrl

Frame sequencer for the pipelined DIF FFT chain of `TOTAL_STAGES` stages. Sits between the sample source and the first stage, and between the last stage and the consumer.
- Input side: accepts samples, counts them into N = 2^TOTAL_STAGES frames and pushes them into the pipeline.
- Output side: tags pipeline output with frame markers and bit-reversed bin indices, and accumulates per-frame clip status.
- Flush: on request, completes any partial frame with zeros, then pads zeros until every real frame has emerged. It then re-initialises the pipeline.

## Interface
Parameters
- `IN_W`, 10: input sample width, signed I and Q.
- `TOTAL_STAGES`, 8: log2 of N, the FFT length.
- `OUT_W`, IN_W+TOTAL_STAGES: pipeline and output sample width.
- `MAX_INFLIGHT`, 3: maximum number of real frames started in the pipeline but not yet fully output.

Ports
- `mclk` in 1: the single clock.
- `i_init` in 1: reset, synchronous, active-high.
- `i_vld` in 1: input sample valid.
- `i_I`, `i_Q` in IN_W: input sample, signed.
- `i_flush` in 1: flush request, sampled only in RUN.
- `o_rdy` out 1: input accepted when `i_vld & o_rdy`.
- `o_p_init` out 1: pipeline reset.
- `o_p_vld` out 1: pipeline input valid.
- `o_p_I`, `o_p_Q` out IN_W: pipeline input sample.
- `i_p_vld` in 1: pipeline output valid.
- `i_p_I`, `i_p_Q` in OUT_W: pipeline output sample.
- `i_p_clip_strb` in 1: OR of all stage clip strobes.
- `o_vld` out 1: output valid.
- `o_I`, `o_Q` out OUT_W: output sample.
- `o_sof` out 1: first sample of an output frame.
- `o_eof` out 1: last sample of an output frame.
- `o_bin` out TOTAL_STAGES: frequency bin of the current output sample.
- `o_frame_clip` out 1: frame clipped; valid only with `o_eof`.
- `o_flush_done` out 1: one-cycle pulse at flush completion.

## Operation
- State machine: RUN, PAD, DRAIN.
- Counters:
  - `in_cnt` (TOTAL_STAGES bits) counts samples pushed into the current frame.
  - `out_cnt` (TOTAL_STAGES bits) counts output samples.
  - `R` counts real frames in flight.
- RUN:
  - `o_rdy = ~i_init & ~(in_cnt==0 & R==MAX_INFLIGHT)`.
  - Each accepted sample is pushed to the pipeline and increments `in_cnt`.
  - Accepting a sample with `in_cnt==0` increments `R`.
- Flush request in RUN:
  - `in_cnt != 0`: go to PAD.
  - `in_cnt == 0` and `R > 0`: go to DRAIN.
  - Otherwise: stay in RUN and pulse `o_flush_done` the next cycle.
- PAD:
  - `o_rdy = 0`.
  - Pushes zero samples every cycle. When `in_cnt` wraps to 0, go to DRAIN.
- DRAIN:
  - `o_rdy = 0`.
  - Pushes zero samples every cycle. These do not increment `R`.
  - When `R` reaches 0, assert `o_p_init` for one cycle, clear `in_cnt`/`out_cnt`, pulse `o_flush_done`, and return to RUN.
- Output path (every `i_p_vld` cycle):
  - Increments `out_cnt`, wrapping at N.
  - Output is suppressed (`o_vld` = 0) when `R == 0`, which discards drain garbage.
- `out_cnt` wrap on a sample emitted while `R > 0` decrements `R`.
  - If a frame starts and one ends in the same cycle, `R` is unchanged.
- Output fields per emitted sample:
  - `o_sof` is set when `out_cnt==0`.
  - `o_eof` is set when `out_cnt==N-1`.
  - `o_bin` is the bit-reversal of `out_cnt` (DIF output order).
- Clip accumulation:
  - A sticky flag ORs `i_p_clip_strb` over the frame.
  - `o_frame_clip` = sticky | the strobe in the eof cycle. The sticky flag clears after eof.
- `o_p_init = i_init | drain-completion pulse`.
- Widths:
  - Samples pass through unmodified; pad samples are all-zero.
  - `R` is clog2(MAX_INFLIGHT+1) bits and never exceeds MAX_INFLIGHT.

## Timing
- Reset (`i_init` high, sampled at the edge):
  - Next cycle: state RUN, all counters and sticky flags 0.
  - `o_p_vld`, `o_vld`, `o_sof`, `o_eof`, `o_frame_clip`, `o_flush_done` are 0; `o_bin`, data outputs 0.
  - `o_rdy` is 0 while `i_init` is high.
  - Reset mid-frame or mid-flush aborts immediately. No `o_flush_done` pulse is produced.
- Input pipeline: `o_p_vld`/`o_p_I`/`o_p_Q` are registered, 1 cycle after acceptance or pad push.
- Output path: registered. `o_vld` and all output fields appear 1 cycle after `i_p_vld`.
- Drain completion: `o_p_init` asserts on the same edge that state returns to RUN. `o_flush_done` is registered on that same edge.
- `i_flush` while in PAD or DRAIN is ignored. `i_vld` when `o_rdy=0` is dropped; the source must hold it.
- Input is never stalled by the pipeline.

## Test plan
- N=256, two contiguous frames of ramp data:
  - `o_p_vld` tracks accepts with 1-cycle lag.
  - Outputs give 512 `o_vld`; `o_sof` at sample indices 0 and 256, `o_eof` at 255 and 511.
  - `o_bin` sequence starts 0, 128, 64, 192.
- 100 samples, then `i_flush`:
  - `o_rdy` drops; 156 zero pushes, then drain zeros.
  - Exactly 256 outputs; `o_flush_done` pulses once, with `o_p_init` on the same edge.
  - `o_rdy` returns to 1.
- Clip strobe pulsed once mid-frame 0, none in frame 1: `o_frame_clip`=1 at eof 0, 0 at eof 1.
- Pipeline model holding `i_p_vld` low: after MAX_INFLIGHT (3) frame starts, `o_rdy`=0 at the start of the 4th frame. It rises the cycle after the first output eof.
- `i_init` asserted at `in_cnt`=37 during DRAIN:
  - Next cycle all outputs are 0 and the state is RUN.
  - A subsequent full frame outputs correctly from `o_sof`.
- `i_flush` with `R`=0 and `in_cnt`=0: no pad pushes, `o_flush_done` the next cycle, `o_p_init` stays 0.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer around a pipelined DIF FFT: frames the input stream, flushes with
// zero padding, and tags pipeline output with frame markers, bit-reversed bins and clip status.
module fft_seq_ctrl #(
  parameter int IN_W         = 10,
  parameter int TOTAL_STAGES = 8,
  parameter int OUT_W        = IN_W + TOTAL_STAGES,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                           mclk,
  input  logic                           i_init,
  input  logic                           i_vld,
  input  logic signed [IN_W-1:0]         i_I,
  input  logic signed [IN_W-1:0]         i_Q,
  input  logic                           i_flush,
  output logic                           o_rdy,
  output logic                           o_p_init,
  output logic                           o_p_vld,
  output logic signed [IN_W-1:0]         o_p_I,
  output logic signed [IN_W-1:0]         o_p_Q,
  input  logic                           i_p_vld,
  input  logic signed [OUT_W-1:0]        i_p_I,
  input  logic signed [OUT_W-1:0]        i_p_Q,
  input  logic                           i_p_clip_strb,
  output logic                           o_vld,
  output logic signed [OUT_W-1:0]        o_I,
  output logic signed [OUT_W-1:0]        o_Q,
  output logic                           o_sof,
  output logic                           o_eof,
  output logic [TOTAL_STAGES-1:0]        o_bin,
  output logic                           o_frame_clip,
  output logic                           o_flush_done
);

  localparam int RW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [TOTAL_STAGES-1:0] CNT_LAST = '1;
  localparam logic [TOTAL_STAGES-1:0] CNT_ONE  = TOTAL_STAGES'(1);
  localparam logic [RW-1:0]           R_MAX    = RW'(MAX_INFLIGHT);
  localparam logic [RW-1:0]           R_ONE    = RW'(1);

  typedef enum logic [1:0] {RUN, PAD, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [TOTAL_STAGES-1:0] in_cnt, in_cnt_nxt;
  logic [TOTAL_STAGES-1:0] out_cnt;
  logic [RW-1:0]           r_cnt, r_nxt;
  logic                    init_pulse_p1;
  logic                    sticky;
  logic                    rdy, accept, push, drain_done, flush_now;
  logic                    p_live, emit, emit_eof, frame_start, frame_end;

  function automatic logic [TOTAL_STAGES-1:0] bit_rev(input logic [TOTAL_STAGES-1:0] v);
    logic [TOTAL_STAGES-1:0] r;
    for (int k = 0; k < TOTAL_STAGES; k++) r[k] = v[TOTAL_STAGES-1-k];
    return r;
  endfunction

  assign rdy    = (state == RUN) & ~i_init & ~((in_cnt == '0) & (r_cnt == R_MAX));
  assign o_rdy  = rdy;
  assign accept = i_vld & rdy;

  // Pipeline output is stale while the pipeline itself is being reset.
  assign p_live      = i_p_vld & ~init_pulse_p1;
  assign emit        = p_live & (r_cnt != '0);
  assign emit_eof    = emit & (out_cnt == CNT_LAST);
  assign frame_start = accept & (in_cnt == '0);
  assign frame_end   = emit_eof;

  assign o_p_init = i_init | init_pulse_p1;

  always_comb begin
    state_nxt  = state;
    in_cnt_nxt = in_cnt;
    r_nxt      = r_cnt;
    push       = 1'b0;
    drain_done = 1'b0;
    flush_now  = 1'b0;
    case ({frame_start, frame_end})
      2'b10:   r_nxt = r_cnt + R_ONE;
      2'b01:   r_nxt = r_cnt - R_ONE;
      default: r_nxt = r_cnt;
    endcase
    case (state)
      RUN: begin
        push = accept;
        if (accept) in_cnt_nxt = in_cnt + CNT_ONE;
        if (i_flush) begin
          if (in_cnt_nxt != '0)  state_nxt = PAD;
          else if (r_nxt != '0)  state_nxt = DRAIN;
          else                   flush_now = 1'b1;
        end
      end
      PAD: begin
        push       = 1'b1;
        in_cnt_nxt = in_cnt + CNT_ONE;
        if (in_cnt == CNT_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_nxt == '0) begin
          drain_done = 1'b1;
          in_cnt_nxt = '0;
          state_nxt  = RUN;
        end else begin
          push       = 1'b1;
          in_cnt_nxt = in_cnt + CNT_ONE;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Control state
  always_ff @(posedge mclk) begin
    if (i_init) begin
      state         <= RUN;
      in_cnt        <= '0;
      out_cnt       <= '0;
      r_cnt         <= '0;
      sticky        <= 1'b0;
      init_pulse_p1 <= 1'b0;
      o_flush_done  <= 1'b0;
    end else begin
      state         <= state_nxt;
      in_cnt        <= in_cnt_nxt;
      r_cnt         <= r_nxt;
      init_pulse_p1 <= drain_done;
      o_flush_done  <= drain_done | flush_now;
      if (drain_done)  out_cnt <= '0;
      else if (p_live) out_cnt <= out_cnt + CNT_ONE;
      if (emit_eof || drain_done)                     sticky <= 1'b0;
      else if (i_p_clip_strb && r_cnt != '0 && !init_pulse_p1) sticky <= 1'b1;
    end
  end

  // Input stage p1: accepted samples or zero pad toward the pipeline
  always_ff @(posedge mclk) begin
    if (i_init) begin
      o_p_vld <= 1'b0;
      o_p_I   <= '0;
      o_p_Q   <= '0;
    end else begin
      o_p_vld <= push;
      o_p_I   <= (state == RUN && accept) ? i_I : '0;
      o_p_Q   <= (state == RUN && accept) ? i_Q : '0;
    end
  end

  // Output stage p1: tagged pipeline samples toward the consumer
  always_ff @(posedge mclk) begin
    if (i_init) begin
      o_vld        <= 1'b0;
      o_I          <= '0;
      o_Q          <= '0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_bin        <= '0;
      o_frame_clip <= 1'b0;
    end else begin
      o_vld        <= emit;
      o_I          <= emit ? i_p_I : '0;
      o_Q          <= emit ? i_p_Q : '0;
      o_sof        <= emit & (out_cnt == '0);
      o_eof        <= emit_eof;
      o_bin        <= emit ? bit_rev(out_cnt) : '0;
      o_frame_clip <= emit_eof & (sticky | i_p_clip_strb);
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: delay-queue pipeline model and an output scoreboard
// that predicts sample data, bin, frame markers and frame clip.
`timescale 1ns/1ps
module tb_fft_seq_ctrl;
  localparam int IN_W = 10;
  localparam int TS   = 8;
  localparam int OUT_W = IN_W + TS;
  localparam int N    = 256;
  localparam int LAT  = 64;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic                    i_init, i_vld, i_flush;
  logic signed [IN_W-1:0]  i_I, i_Q;
  logic                    o_rdy, o_p_init, o_p_vld;
  logic signed [IN_W-1:0]  o_p_I, o_p_Q;
  logic                    i_p_vld, i_p_clip_strb;
  logic signed [OUT_W-1:0] i_p_I, i_p_Q;
  logic                    o_vld, o_sof, o_eof, o_frame_clip, o_flush_done;
  logic signed [OUT_W-1:0] o_I, o_Q;
  logic [TS-1:0]           o_bin;

  fft_seq_ctrl #(.IN_W(IN_W), .TOTAL_STAGES(TS), .OUT_W(OUT_W), .MAX_INFLIGHT(3)) dut (
    .mclk(mclk), .i_init(i_init), .i_vld(i_vld), .i_I(i_I), .i_Q(i_Q), .i_flush(i_flush),
    .o_rdy(o_rdy), .o_p_init(o_p_init), .o_p_vld(o_p_vld), .o_p_I(o_p_I), .o_p_Q(o_p_Q),
    .i_p_vld(i_p_vld), .i_p_I(i_p_I), .i_p_Q(i_p_Q), .i_p_clip_strb(i_p_clip_strb),
    .o_vld(o_vld), .o_I(o_I), .o_Q(o_Q), .o_sof(o_sof), .o_eof(o_eof), .o_bin(o_bin),
    .o_frame_clip(o_frame_clip), .o_flush_done(o_flush_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [TS-1:0] bitrev(input logic [TS-1:0] v);
    logic [TS-1:0] r;
    for (int k = 0; k < TS; k++) r[k] = v[TS-1-k];
    return r;
  endfunction

  // Scoreboard of expected consumer-side samples
  typedef struct {
    logic [OUT_W-1:0] i;
    logic [OUT_W-1:0] q;
    int               idx;
    bit               clip;
  } exp_t;
  exp_t sb[$];
  int in_idx = 0, frames_pushed = 0, clip_frame = -1;

  function automatic void sb_push(input logic signed [IN_W-1:0] iv, input logic signed [IN_W-1:0] qv);
    exp_t e;
    logic signed [OUT_W-1:0] ti, tq;
    ti = iv;
    tq = qv;
    e.i    = ti;
    e.q    = tq;
    e.idx  = in_idx;
    e.clip = (in_idx == N-1) && (frames_pushed == clip_frame);
    sb.push_back(e);
    if (in_idx == N-1) frames_pushed++;
    in_idx = (in_idx + 1) % N;
  endfunction

  // Pipeline model: fixed latency, optional output hold, cleared by o_p_init
  typedef struct {
    logic [IN_W-1:0] i;
    logic [IN_W-1:0] q;
    int              t;
  } pe_t;
  pe_t pq[$];
  pe_t pe, pin;
  int cyc = 0, pops = 0, clip_pop = -1;
  bit hold = 1'b0;

  always @(negedge mclk) begin
    #2;
    cyc++;
    i_p_clip_strb = 1'b0;
    if (o_p_init) begin
      pq.delete();
      i_p_vld = 1'b0;
    end else begin
      if (!hold && pq.size() > 0 && pq[0].t + LAT <= cyc) begin
        pe = pq.pop_front();
        i_p_vld = 1'b1;
        i_p_I = {{(OUT_W-IN_W){pe.i[IN_W-1]}}, pe.i};
        i_p_Q = {{(OUT_W-IN_W){pe.q[IN_W-1]}}, pe.q};
        if (pops == clip_pop) i_p_clip_strb = 1'b1;
        pops++;
      end else begin
        i_p_vld = 1'b0;
      end
      if (o_p_vld) begin
        pin.i = o_p_I;
        pin.q = o_p_Q;
        pin.t = cyc;
        pq.push_back(pin);
      end
    end
  end

  // Consumer-side monitor
  int n_out = 0, fd_cnt = 0;
  exp_t got;
  always @(negedge mclk) begin
    #1;
    if (o_flush_done) fd_cnt++;
    if (o_vld) begin
      n_out++;
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        check("o_I", 64'($unsigned(o_I)), 64'(got.i));
        check("o_Q", 64'($unsigned(o_Q)), 64'(got.q));
        check("o_bin", 64'(o_bin), 64'(bitrev(TS'(got.idx))));
        check("o_sof", 64'(o_sof), 64'(got.idx == 0));
        check("o_eof", 64'(o_eof), 64'(got.idx == N-1));
        if (got.idx == N-1) check("o_frame_clip", 64'(o_frame_clip), 64'(got.clip));
      end
    end
  end

  // Pipeline-input monitor: o_p_vld/o_p_I follow accepts by one cycle
  bit acc_now = 1'b0, acc_prev = 1'b0, chk_pin = 1'b0;
  logic [IN_W-1:0] acc_i_now, acc_i_prev;
  always @(negedge mclk) begin
    #3;
    if (chk_pin) begin
      check("o_p_vld_lag", 64'(o_p_vld), 64'(acc_prev));
      if (acc_prev) check("o_p_I_lag", 64'($unsigned(o_p_I)), 64'(acc_i_prev));
    end
    acc_prev   = acc_now;
    acc_i_prev = acc_i_now;
    acc_now    = 1'b0;
  end

  task automatic send(input logic [IN_W-1:0] iv, input logic [IN_W-1:0] qv);
    int w = 0;
    @(negedge mclk);
    i_vld = 1'b1;
    i_I = iv;
    i_Q = qv;
    #1;
    while (!o_rdy && w < 2000) begin
      @(negedge mclk);
      #1;
      w++;
    end
    if (o_rdy) begin
      acc_now   = 1'b1;
      acc_i_now = iv;
      sb_push(iv, qv);
    end else begin
      check("send_timeout", 64'(o_rdy), 64'd1);
    end
  endtask

  task automatic idle();
    @(negedge mclk);
    i_vld = 1'b0;
  endtask

  task automatic flush();
    @(negedge mclk);
    i_vld   = 1'b0;
    i_flush = 1'b1;
    @(negedge mclk);
    i_flush = 1'b0;
    if (in_idx != 0) begin
      while (in_idx != 0) sb_push('0, '0);
    end
  endtask

  task automatic wait_empty(input int limit);
    int w = 0;
    while (sb.size() > 0 && w < limit) begin
      @(negedge mclk);
      w++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (4) @(negedge mclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, fd0, cnt, w;
    i_init = 1'b1; i_vld = 1'b0; i_flush = 1'b0; i_I = '0; i_Q = '0;
    i_p_vld = 1'b0; i_p_I = '0; i_p_Q = '0; i_p_clip_strb = 1'b0;
    repeat (3) @(negedge mclk);
    #1;
    check("rdy_in_init", 64'(o_rdy), 64'd0);
    check("p_init_in_init", 64'(o_p_init), 64'd1);
    @(negedge mclk);
    i_init = 1'b0;
    #1;
    check("rst_rdy", 64'(o_rdy), 64'd1);
    check("rst_p_vld", 64'(o_p_vld), 64'd0);
    check("rst_vld", 64'(o_vld), 64'd0);
    check("rst_p_init", 64'(o_p_init), 64'd0);
    check("rst_flush_done", 64'(o_flush_done), 64'd0);
    check("rst_bin", 64'(o_bin), 64'd0);
    check("rst_o_I", 64'($unsigned(o_I)), 64'd0);

    // Two contiguous ramp frames
    n0 = n_out;
    chk_pin = 1'b1;
    for (int k = 0; k < 2*N; k++) send(IN_W'(k), IN_W'(-k));
    idle();
    @(negedge mclk);
    @(negedge mclk);
    chk_pin = 1'b0;
    wait_empty(2000);
    check("frames2_count", 64'(n_out - n0), 64'(2*N));

    // Partial frame of 100 then flush
    n0 = n_out; fd0 = fd_cnt;
    for (int k = 0; k < 100; k++) send(IN_W'($urandom), IN_W'($urandom));
    flush();
    #1;
    check("rdy_pad", 64'(o_rdy), 64'd0);
    w = 0;
    while (!o_flush_done && w < 3000) begin
      @(negedge mclk);
      #1;
      w++;
    end
    check("flush_done_seen", 64'(o_flush_done), 64'd1);
    check("p_init_with_done", 64'(o_p_init), 64'd1);
    @(negedge mclk);
    #1;
    check("rdy_after_flush", 64'(o_rdy), 64'd1);
    check("done_one_cycle", 64'(o_flush_done), 64'd0);
    check("p_init_one_cycle", 64'(o_p_init), 64'd0);
    repeat (3) @(negedge mclk);
    #2;
    check("flush_out_count", 64'(n_out - n0), 64'(N));
    check("flush_sb_empty", 64'(sb.size()), 64'd0);
    check("flush_done_pulses", 64'(fd_cnt - fd0), 64'd1);

    // Clip strobe on sample 100 of frame 0 only
    clip_frame = frames_pushed;
    clip_pop   = pops + 100;
    for (int k = 0; k < 2*N; k++) send(IN_W'($urandom), IN_W'($urandom));
    idle();
    wait_empty(2000);
    clip_pop = -1;

    // In-flight limit with the pipeline output held
    hold = 1'b1;
    for (int k = 0; k < 3*N; k++) send(IN_W'(k + 7), IN_W'(k * 3));
    @(negedge mclk);
    i_vld = 1'b1; i_I = IN_W'(55); i_Q = IN_W'(-55);
    #1;
    check("rdy_full", 64'(o_rdy), 64'd0);
    repeat (3) @(negedge mclk);
    #1;
    check("rdy_full_hold", 64'(o_rdy), 64'd0);
    hold = 1'b0;
    w = 0;
    while (!(o_vld && o_eof) && w < 2000) begin
      check("rdy_wait_eof", 64'(o_rdy), 64'd0);
      @(negedge mclk);
      #1;
      w++;
    end
    check("eof_seen", 64'(o_vld && o_eof), 64'd1);
    check("rdy_after_eof", 64'(o_rdy), 64'd1);
    if (o_rdy) sb_push(IN_W'(55), IN_W'(-55));
    for (int k = 1; k < N; k++) send(IN_W'($urandom), IN_W'($urandom));
    idle();
    wait_empty(4000);

    // Reset in DRAIN with in_cnt at 37
    fd0 = fd_cnt;
    for (int k = 0; k < 10; k++) send(IN_W'(k + 100), IN_W'(k));
    flush();
    cnt = 0; w = 0;
    while (cnt < (N - 10) + 37 && w < 1000) begin
      @(negedge mclk);
      #1;
      if (o_p_vld) cnt++;
      w++;
    end
    check("drain_push_count", 64'(cnt), 64'((N - 10) + 37));
    i_init = 1'b1;
    @(negedge mclk);
    i_init = 1'b0;
    sb.delete();
    in_idx = 0;
    #1;
    check("init_rdy", 64'(o_rdy), 64'd1);
    check("init_p_vld", 64'(o_p_vld), 64'd0);
    check("init_p_I", 64'($unsigned(o_p_I)), 64'd0);
    check("init_vld", 64'(o_vld), 64'd0);
    check("init_sof", 64'(o_sof), 64'd0);
    check("init_eof", 64'(o_eof), 64'd0);
    check("init_clip", 64'(o_frame_clip), 64'd0);
    check("init_done", 64'(o_flush_done), 64'd0);
    check("init_p_init", 64'(o_p_init), 64'd0);
    check("init_bin", 64'(o_bin), 64'd0);
    check("init_o_I", 64'($unsigned(o_I)), 64'd0);
    n0 = n_out;
    for (int k = 0; k < N; k++) send(IN_W'($urandom), IN_W'($urandom));
    idle();
    wait_empty(2000);
    check("post_init_count", 64'(n_out - n0), 64'(N));
    check("no_done_after_init", 64'(fd_cnt - fd0), 64'd0);

    // Flush with nothing in flight
    @(negedge mclk);
    i_flush = 1'b1;
    #1;
    check("idle_flush_done_early", 64'(o_flush_done), 64'd0);
    @(negedge mclk);
    i_flush = 1'b0;
    #1;
    check("idle_flush_done", 64'(o_flush_done), 64'd1);
    check("idle_flush_p_init", 64'(o_p_init), 64'd0);
    check("idle_flush_p_vld", 64'(o_p_vld), 64'd0);
    check("idle_flush_rdy", 64'(o_rdy), 64'd1);
    @(negedge mclk);
    #1;
    check("idle_flush_done_end", 64'(o_flush_done), 64'd0);
    check("idle_flush_no_pad", 64'(o_p_vld), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
